// File: rtl/branch_update_arbiter.sv
// rtl/branch_update_arbiter.sv - round-robin arbiter and FIFO feeding the branch predictor/BTB update port
//
// Purpose: accepts resolved-branch records from two sources (req0: conditional
// resolve, req1: jump/indirect resolve), arbitrates them round-robin into a
// DEPTH-entry FIFO and issues at most one record per cycle to the predictor.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   upd_hold                  suppress issue while 1
//   reqN_valid / reqN_ready   per-source handshake (ready depends on valids)
//   reqN_upd_pred/upd_btb     record training flags (both 0 = null record)
//   reqN_taken/pc/target      record payload
//   update_predictor/btb      issue strobes
//   actually_taken, resolved_pc, resolved_pc_target   issued record
//   busy, count               FIFO non-empty / occupancy
//
// Optional feature: define BRANCH_UPD_BYPASS_EN to let a granted record skip
// the FIFO when it is empty and not held.

module branch_update_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        upd_hold,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic                        req0_upd_pred,
  input  logic                        req0_upd_btb,
  input  logic                        req0_taken,
  input  logic [DATA_WIDTH-1:0]       req0_pc,
  input  logic [DATA_WIDTH-1:0]       req0_target,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic                        req1_upd_pred,
  input  logic                        req1_upd_btb,
  input  logic                        req1_taken,
  input  logic [DATA_WIDTH-1:0]       req1_pc,
  input  logic [DATA_WIDTH-1:0]       req1_target,
  output logic                        update_predictor,
  output logic                        update_btb,
  output logic                        actually_taken,
  output logic [DATA_WIDTH-1:0]       resolved_pc,
  output logic [DATA_WIDTH-1:0]       resolved_pc_target,
  output logic                        busy,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Record layout: {upd_pred, upd_btb, taken, pc, target}
  localparam int RW = 3 + 2 * DATA_WIDTH;

  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          rr;

  logic          full;
  logic          empty;
  logic          grant0;
  logic          grant1;
  logic          any_grant;
  logic [RW-1:0] rec0;
  logic [RW-1:0] rec1;
  logic [RW-1:0] sel_rec;
  logic [RW-1:0] head;
  logic          sel_null;
  logic          bypass_take;
  logic          accept;
  logic          push;
  logic          pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // rr=1 means req1 wins a tie; a lone requester always wins.
  assign grant0    = req0_valid & (~req1_valid | ~rr);
  assign grant1    = req1_valid & (~req0_valid |  rr);
  assign any_grant = grant0 | grant1;

  assign rec0    = {req0_upd_pred, req0_upd_btb, req0_taken, req0_pc, req0_target};
  assign rec1    = {req1_upd_pred, req1_upd_btb, req1_taken, req1_pc, req1_target};
  assign sel_rec = grant1 ? rec1 : rec0;
  assign sel_null = ~sel_rec[RW-1] & ~sel_rec[RW-2];

`ifdef BRANCH_UPD_BYPASS_EN
  assign bypass_take = any_grant & ~sel_null & empty & ~upd_hold;
`else
  assign bypass_take = 1'b0;
`endif

  // Null records are swallowed even when full; a full FIFO never takes a push,
  // regardless of a concurrent pop, so ready never depends on the hold input.
  assign accept = any_grant & (sel_null | bypass_take | ~full);
  assign push   = accept & ~sel_null & ~bypass_take;
  assign pop    = ~empty & ~upd_hold;

  assign req0_ready = grant0 & accept;
  assign req1_ready = grant1 & accept;

  assign head  = mem[rd_ptr];
  assign busy  = ~empty;
  assign count = cnt;

  always_comb begin
    update_predictor   = 1'b0;
    update_btb         = 1'b0;
    actually_taken     = 1'b0;
    resolved_pc        = '0;
    resolved_pc_target = '0;
    if (bypass_take) begin
      update_predictor   = sel_rec[RW-1];
      update_btb         = sel_rec[RW-2];
      actually_taken     = sel_rec[RW-3];
      resolved_pc        = sel_rec[2*DATA_WIDTH-1:DATA_WIDTH];
      resolved_pc_target = sel_rec[DATA_WIDTH-1:0];
    end else if (!empty) begin
      update_predictor   = pop & head[RW-1];
      update_btb         = pop & head[RW-2];
      actually_taken     = head[RW-3];
      resolved_pc        = head[2*DATA_WIDTH-1:DATA_WIDTH];
      resolved_pc_target = head[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rr     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      // After granting req0 favour req1 next, and vice versa.
      if (accept) begin
        rr <= grant0;
      end
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sel_rec;
    end
  end

endmodule

// File: tb/tb_branch_update_arbiter.sv
// tb/tb_branch_update_arbiter.sv - directed self-checking bench for branch_update_arbiter

module tb_branch_update_arbiter;

  logic        clk;
  logic        rstn;
  logic        upd_hold;
  logic        req0_valid, req0_ready, req0_upd_pred, req0_upd_btb, req0_taken;
  logic [31:0] req0_pc, req0_target;
  logic        req1_valid, req1_ready, req1_upd_pred, req1_upd_btb, req1_taken;
  logic [31:0] req1_pc, req1_target;
  logic        update_predictor, update_btb, actually_taken, busy;
  logic [31:0] resolved_pc, resolved_pc_target;
  logic [2:0]  count;

  int pass_cnt;
  int total_cnt;

  branch_update_arbiter #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .upd_hold(upd_hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_upd_pred(req0_upd_pred), .req0_upd_btb(req0_upd_btb),
    .req0_taken(req0_taken), .req0_pc(req0_pc), .req0_target(req0_target),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_upd_pred(req1_upd_pred), .req1_upd_btb(req1_upd_btb),
    .req1_taken(req1_taken), .req1_pc(req1_pc), .req1_target(req1_target),
    .update_predictor(update_predictor), .update_btb(update_btb),
    .actually_taken(actually_taken), .resolved_pc(resolved_pc),
    .resolved_pc_target(resolved_pc_target), .busy(busy), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    upd_hold = 1'b0;
    req0_valid = 1'b0; req0_upd_pred = 1'b0; req0_upd_btb = 1'b0; req0_taken = 1'b0;
    req0_pc = '0; req0_target = '0;
    req1_valid = 1'b0; req1_upd_pred = 1'b0; req1_upd_btb = 1'b0; req1_taken = 1'b0;
    req1_pc = '0; req1_target = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt = 0;
    total_cnt = 0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_upd_pred", 32'(update_predictor), 0);
    check("rst_pc", resolved_pc, 0);
    tick();

    // Single record, 1-cycle latency
    req0_valid = 1; req0_upd_pred = 1; req0_upd_btb = 1; req0_taken = 1;
    req0_pc = 32'h100; req0_target = 32'h200;
    @(negedge clk);
    check("t1_ready", 32'(req0_ready), 1);
    check("t1_no_issue_yet", 32'(update_predictor), 0);
    tick();
    req0_valid = 0;
    @(negedge clk);
    check("t1_upd_pred", 32'(update_predictor), 1);
    check("t1_upd_btb", 32'(update_btb), 1);
    check("t1_taken", 32'(actually_taken), 1);
    check("t1_pc", resolved_pc, 32'h100);
    check("t1_target", resolved_pc_target, 32'h200);
    check("t1_count", 32'(count), 1);
    tick();
    @(negedge clk);
    check("t1_count_after", 32'(count), 0);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_strobe_after", 32'(update_predictor), 0);

    // Round-robin: both valid for 4 cycles
    do_reset();
    req0_valid = 1; req0_upd_pred = 1; req0_upd_btb = 0; req0_taken = 0;
    req0_pc = 32'h10; req0_target = 32'h1010;
    req1_valid = 1; req1_upd_pred = 1; req1_upd_btb = 1; req1_taken = 1;
    req1_pc = 32'h80; req1_target = 32'h1080;
    begin
      logic [31:0] exp_issue [4];
      exp_issue[0] = 32'h10; exp_issue[1] = 32'h80;
      exp_issue[2] = 32'h14; exp_issue[3] = 32'h84;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check($sformatf("rr_r0_ready_%0d", i), 32'(req0_ready), (i % 2 == 0) ? 1 : 0);
        check($sformatf("rr_r1_ready_%0d", i), 32'(req1_ready), (i % 2 == 1) ? 1 : 0);
        if (i > 0) begin
          check($sformatf("rr_issue_pc_%0d", i), resolved_pc, exp_issue[i-1]);
          check($sformatf("rr_issue_stb_%0d", i), 32'(update_predictor), 1);
        end
        tick();
        if (i % 2 == 0) req0_pc = req0_pc + 4;
        else            req1_pc = req1_pc + 4;
      end
      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      check("rr_issue_pc_4", resolved_pc, exp_issue[3]);
      check("rr_issue_btb_4", 32'(update_btb), 1);
      tick();
      @(negedge clk);
      check("rr_busy_end", 32'(busy), 0);
    end

    // Hold while streaming req0 for 6 cycles
    do_reset();
    upd_hold = 1;
    req0_valid = 1; req0_upd_pred = 1; req0_upd_btb = 1; req0_taken = 0;
    req0_pc = 32'h300; req0_target = 32'h400;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("hold_ready_%0d", i), 32'(req0_ready), (i < 4) ? 1 : 0);
      check($sformatf("hold_no_stb_%0d", i), 32'(update_predictor), 0);
      tick();
      if (i < 4) req0_pc = req0_pc + 4;
      check($sformatf("hold_count_%0d", i), 32'(count), (i < 4) ? i + 1 : 4);
    end
    req0_valid = 0;

    // Null record on req1 while full
    req1_valid = 1; req1_upd_pred = 0; req1_upd_btb = 0; req1_taken = 1;
    req1_pc = 32'hDEAD; req1_target = 32'hBEEF;
    @(negedge clk);
    check("null_ready", 32'(req1_ready), 1);
    tick();
    req1_valid = 0;
    check("null_count", 32'(count), 4);

    // Release hold: 4 back-to-back issues
    upd_hold = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("drain_stb_%0d", k), 32'(update_predictor), 1);
      check($sformatf("drain_pc_%0d", k), resolved_pc, 32'h300 + 32'(4 * k));
      tick();
    end
    @(negedge clk);
    check("drain_busy", 32'(busy), 0);
    check("drain_no_null_stb", 32'(update_predictor) | 32'(update_btb), 0);

    // Reset mid-operation with count=3
    do_reset();
    upd_hold = 1;
    req0_valid = 1; req0_upd_pred = 1; req0_upd_btb = 1; req0_taken = 1;
    req0_pc = 32'h500; req0_target = 32'h550;
    for (int i = 0; i < 3; i++) begin
      tick();
      req0_pc = req0_pc + 4;
    end
    req0_valid = 0;
    upd_hold = 0;
    @(negedge clk);
    check("mid_count_3", 32'(count), 3);
    check("mid_stb_pre", 32'(update_predictor), 1);
    #1 rstn = 0;
    #1;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_stb", 32'(update_predictor), 0);
    check("mid_rst_pc", resolved_pc, 0);
    tick();
    rstn = 1;
    req0_valid = 1; req0_pc = 32'h600; req0_target = 32'h700; req0_taken = 0;
    tick();
    req0_valid = 0;
    @(negedge clk);
    check("post_rst_count", 32'(count), 1);
    check("post_rst_pc", resolved_pc, 32'h600);
    check("post_rst_target", resolved_pc_target, 32'h700);
    check("post_rst_taken", 32'(actually_taken), 0);
    tick();
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);

    // Push and pop in the same cycle at count=2
    tick();
    upd_hold = 1;
    req0_valid = 1; req0_taken = 1; req0_pc = 32'h900; req0_target = 32'h990;
    tick();
    req0_pc = 32'h904;
    tick();
    check("pp_count_2", 32'(count), 2);
    upd_hold = 0;
    req0_pc = 32'h908;
    @(negedge clk);
    check("pp_ready", 32'(req0_ready), 1);
    check("pp_stb", 32'(update_predictor), 1);
    check("pp_pc_oldest", resolved_pc, 32'h900);
    tick();
    req0_valid = 0;
    check("pp_count_stays", 32'(count), 2);
    @(negedge clk);
    check("pp_next_pc", resolved_pc, 32'h904);
    tick();
    @(negedge clk);
    check("pp_last_pc", resolved_pc, 32'h908);
    tick();
    check("pp_empty", 32'(count), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
